// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the serial program loader.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Big-endian byte-to-word shift register with a byte position counter.
module word_assembler
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [BCNT_W-1:0] bcnt;

  // Shift each accepted byte in from the bottom so the first byte lands in [31:24].
  // The counter wraps to 0 on the last byte, ready for the next word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      bcnt <= '0;
    end else if (shift_en) begin
      word <= {word[23:0], byte_in};
      bcnt <= bcnt + BCNT_W'(1);
    end
  end

  // High while the next accepted byte completes the word.
  assign word_full = (bcnt == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// Boot loader: takes a length-prefixed byte image, writes it into memory as
// 32-bit words, then releases the CPU from reset.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_WORD = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       checksum
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic        accept;
  logic [7:0]  len_hi;
  logic [15:0] len, idx, hdr_len;
  logic [31:0] word;
  logic        word_full;

  assign accept  = byte_valid & byte_ready;
  assign hdr_len = {len_hi, byte_in};

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (accept && (state == S_DATA)),
    .clear     (state == S_IDLE),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; RUN and ERR only leave through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: if (accept) begin
                  if (hdr_len == 16'd0)             state_nxt = S_RUN;
                  else if ({1'b0, hdr_len} > MAX_LEN) state_nxt = S_ERR;
                  else                              state_nxt = S_DATA;
                end
      S_DATA:   if (accept && word_full) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (idx + 16'd1 == len) ? S_RUN : S_DATA;
      default:  state_nxt = state;
    endcase
  end

  // Header capture and per-word bookkeeping on the WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi       <= '0;
      len          <= '0;
      idx          <= '0;
      words_loaded <= '0;
      checksum     <= '0;
    end else begin
      if (state == S_LEN_HI && accept) len_hi <= byte_in;
      if (state == S_LEN_LO && accept) len    <= hdr_len;
      if (state == S_WRITE) begin
        idx          <= idx + 16'd1;
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
        checksum     <= checksum ^ word;
      end
    end
  end

  // Moore outputs decoded from state.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_reset  = 1'b1;
    mem_we     = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA: begin byte_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin busy = 1'b1; mem_we = 1'b1; end
      S_RUN:   begin done = 1'b1; cpu_reset = 1'b0; end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = ADDR_W'(BASE_WORD) + ADDR_W'(idx);
  assign mem_wdata = word;

endmodule
